// File: rtl/mmcm_div_model.sv
// Behavioural MMCM stand-in: lock sequencer plus phase-aligned integer clock dividers.
// Optional macro MMCM_DIV_MODEL_CE_EN adds per-channel clock-enable pulses on CE.
module mmcm_div_model #(
    parameter int                   NUM_OUT     = 4,
    parameter logic [8*NUM_OUT-1:0] DIVIDE_VEC  = {8'd8, 8'd6, 8'd4, 8'd2},
    parameter int                   LOCK_CYCLES = 16
) (
    input  logic               CLKIN1,
    input  logic               RST_N,
    input  logic               PWRDWN,
    output logic [NUM_OUT-1:0] CLKOUT,
    output logic [NUM_OUT-1:0] CE,
    output logic               LOCKED
);

    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOCKING,
        RUN,
        PD
    } state_t;

    state_t                    state_q, state_d;
    logic [LW-1:0]             lock_q, lock_d;
    logic [NUM_OUT-1:0][7:0]   cnt_q, cnt_d;
    logic [NUM_OUT-1:0]        clk_q, clk_d;

    // Out-of-range ratios fall back to divide-by-2.
    function automatic logic [7:0] div_of(input int i);
        logic [7:0] d;
        d = DIVIDE_VEC[8*i +: 8];
        return (d < 8'd2) ? 8'd2 : d;
    endfunction

    // High-phase length: ceil(D/2), widened so D=255 cannot overflow.
    function automatic logic [8:0] half_of(input int i);
        logic [8:0] d9;
        d9 = {1'b0, div_of(i)} + 9'd1;
        return d9 >> 1;
    endfunction

    // Next-state, lock counter and divider outputs; power-down overrides everything.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        cnt_d   = '0;
        clk_d   = '0;
        unique case (state_q)
            IDLE: begin
                state_d = LOCKING;
                lock_d  = '0;
            end
            LOCKING: begin
                if (lock_q == LOCK_LAST) begin
                    state_d = RUN;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_q + LW'(1);
                end
            end
            RUN: state_d = RUN;
            PD: begin
                state_d = LOCKING;
                lock_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        if (PWRDWN) begin
            state_d = PD;
            lock_d  = '0;
        end
        if (state_d == RUN) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (state_q == RUN && cnt_q[i] != div_of(i) - 8'd1)
                    cnt_d[i] = cnt_q[i] + 8'd1;
                else
                    cnt_d[i] = 8'd0;
                clk_d[i] = ({1'b0, cnt_d[i]} < half_of(i));
            end
        end
    end

    // State, lock counter, channel counters and registered clocks.
    always_ff @(posedge CLKIN1 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            lock_q  <= '0;
            cnt_q   <= '0;
            clk_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
        end
    end

    assign CLKOUT = clk_q;
    assign LOCKED = (state_q == RUN);

`ifdef MMCM_DIV_MODEL_CE_EN
    logic [NUM_OUT-1:0] ce_q, ce_d;

    // Enable pulse marks the cycle each channel counter sits at zero in RUN.
    always_comb begin
        ce_d = '0;
        if (state_d == RUN) begin
            for (int i = 0; i < NUM_OUT; i++)
                ce_d[i] = (cnt_d[i] == 8'd0);
        end
    end

    // Registered so CE lines up with the CLKOUT high-phase start.
    always_ff @(posedge CLKIN1 or negedge RST_N) begin
        if (!RST_N)
            ce_q <= '0;
        else
            ce_q <= ce_d;
    end

    assign CE = ce_q;
`else
    assign CE = '0;
`endif

endmodule

// File: tb/tb_mmcm_div_model.sv
// Scoreboard bench for mmcm_div_model: driver pushes model expectations, monitor compares.
// Model counts edges since reset/power-down; outputs follow from modular arithmetic.
module tb_mmcm_div_model;

    localparam int LOCK = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwrdwn = 1'b0;
    logic [2:0] clkout_a, ce_a, clkout_b, ce_b;
    logic       locked_a, locked_b;

    typedef struct packed {
        logic       lk;
        logic [2:0] ca;
        logic [2:0] ea;
        logic [2:0] cb;
        logic [2:0] eb;
    } exp_t;

    exp_t sb[$];
    int   n = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   raw_a[3] = '{2, 3, 5};
    int   raw_b[3] = '{0, 1, 5};

    mmcm_div_model #(
        .NUM_OUT(3),
        .DIVIDE_VEC({8'd5, 8'd3, 8'd2}),
        .LOCK_CYCLES(LOCK)
    ) dut (
        .CLKIN1(clk),
        .RST_N(rst_n),
        .PWRDWN(pwrdwn),
        .CLKOUT(clkout_a),
        .CE(ce_a),
        .LOCKED(locked_a)
    );

    mmcm_div_model #(
        .NUM_OUT(3),
        .DIVIDE_VEC({8'd5, 8'd1, 8'd0}),
        .LOCK_CYCLES(LOCK)
    ) dut_z (
        .CLKIN1(clk),
        .RST_N(rst_n),
        .PWRDWN(pwrdwn),
        .CLKOUT(clkout_b),
        .CE(ce_b),
        .LOCKED(locked_b)
    );

    always #5 clk = ~clk;

    function automatic int eff(input int d);
        return (d < 2 || d > 255) ? 2 : d;
    endfunction

    // n = edges since lock restart; RUN starts once n exceeds LOCK.
    function automatic exp_t model(input int cnt);
        exp_t e;
        int   t, d;
        e = '0;
        e.lk = (cnt > LOCK);
        if (e.lk) begin
            t = cnt - LOCK - 1;
            for (int i = 0; i < 3; i++) begin
                d = eff(raw_a[i]);
                e.ca[i] = (t % d) < ((d + 1) / 2);
`ifdef MMCM_DIV_MODEL_CE_EN
                e.ea[i] = (t % d) == 0;
`endif
                d = eff(raw_b[i]);
                e.cb[i] = (t % d) < ((d + 1) / 2);
`ifdef MMCM_DIV_MODEL_CE_EN
                e.eb[i] = (t % d) == 0;
`endif
            end
        end
        return e;
    endfunction

    task automatic hold_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            n = 0;
            sb.push_back(model(0));
        end
    endtask

    task automatic cycle(input bit p, input bit pulse);
        @(negedge clk);
        if (pulse) begin
            rst_n = 1'b0;
            #1;
            vectors++;
            if (clkout_a !== 3'b0 || clkout_b !== 3'b0 || locked_a !== 1'b0 ||
                locked_b !== 1'b0 || ce_a !== 3'b0 || ce_b !== 3'b0) begin
                miscompares++;
                $display("FAIL async_reset: got lk=%b/%b clk=%b/%b ce=%b/%b want all 0",
                         locked_a, locked_b, clkout_a, clkout_b, ce_a, ce_b);
            end
            #1;
            rst_n = 1'b1;
            n = 0;
        end else begin
            rst_n = 1'b1;
        end
        pwrdwn = p;
        n = p ? 0 : n + 1;
        sb.push_back(model(n));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++)
            cycle(1'b0, 1'b0);
    endtask

    // Monitor: one expectation per rising edge once the driver has started.
    always @(posedge clk) begin
        exp_t e, g;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g = '{lk: locked_a, ca: clkout_a, ea: ce_a, cb: clkout_b, eb: ce_b};
            vectors++;
            if (g !== e || locked_b !== e.lk) begin
                miscompares++;
                $display("FAIL edge_out @%0t: got lk=%b/%b a=%b ce=%b b=%b ce=%b want lk=%b a=%b ce=%b b=%b ce=%b",
                         $time, locked_a, locked_b, clkout_a, ce_a, clkout_b, ce_b,
                         e.lk, e.ca, e.ea, e.cb, e.eb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        hold_reset(3);
        run(40);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0);
        run(30);
        cycle(1'b0, 1'b1);
        run(25);
        cycle(1'b1, 1'b0);
        run(25);
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0);
        run(5);
        @(posedge clk);
        #3;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
